// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 ping-pong FFT sequencer: default sizes,
// the controller state type and the address helper functions.
package fft_pkg;

  localparam int N_DEF        = 512;
  localparam int BFLY_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FIN
  } state_e;

  // Ceiling log2, used at elaboration time to size address fields.
  function automatic int log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Reverses the low w bits of x.
  function automatic logic [31:0] bitrev(input logic [31:0] x, input int w);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < w; j++) r[j] = x[w-1-j];
    return r;
  endfunction

  // Rotates the low w bits of x left by s positions (0 <= s < w).
  function automatic logic [31:0] rotl(input logic [31:0] x, input int s, input int w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return ((x << s) | (x >> (w - s))) & mask;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly address generator: maps (stage, butterfly index) to the two
// operand addresses and the twiddle ROM address. Purely combinational.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int M  = 9,
  parameter int SW = $clog2(M + 1)
) (
  input  logic [SW-1:0] stage_i,
  input  logic [M-2:0]  idx_i,
  output logic [M-1:0]  adr_a_o,
  output logic [M-1:0]  adr_b_o,
  output logic [M-2:0]  twiddle_o
);

  // Operands are the even/odd pair rotated by the stage; the twiddle index
  // keeps only the top s bits of the butterfly index.
  always_comb begin
    adr_a_o   = M'(rotl(32'({idx_i, 1'b0}), int'(stage_i), M));
    adr_b_o   = M'(rotl(32'({idx_i, 1'b1}), int'(stage_i), M));
    twiddle_o = idx_i & ({(M-1){1'b1}} << (M - 1 - int'(stage_i)));
  end

endmodule

// File: rtl/fft_sequencer.sv
// Control and address generation for the ping-pong radix-2 FFT datapath.
// Loads samples bit-reversed into RAM0, runs M stages of N/2 butterflies
// alternating source/destination RAM, drains the butterfly pipeline between
// stages and exposes the result bank on the readout port.
// Optional macro FFT_SEQ_STALL_EN adds a 'stall' input that freezes compute.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int M        = log2(N),
  parameter int BFLY_LAT = BFLY_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   load_valid,
`ifdef FFT_SEQ_STALL_EN
  input  logic                   stall,
`endif
  input  logic [M-1:0]           rd_adr,
  output logic                   busy,
  output logic                   done,
  output logic                   bfly_en,
  output logic                   rd_sel,
  output logic                   we0,
  output logic                   we1,
  output logic [M-1:0]           adr0_a,
  output logic [M-1:0]           adr0_b,
  output logic [M-1:0]           adr1_a,
  output logic [M-1:0]           adr1_b,
  output logic                   load_sel,
  output logic [M-2:0]           twiddle_adr,
  output logic [$clog2(M+1)-1:0] stage
);

  localparam int             SW       = $clog2(M + 1);
  localparam int             DW       = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
  localparam logic [M-2:0]   I_LAST   = '1;
  localparam logic [SW-1:0]  S_LAST   = SW'(M - 1);
  localparam logic [DW-1:0]  D_LAST   = DW'(BFLY_LAT - 1);
  localparam logic           RES_BANK = 1'(M % 2);

  state_e                     state_q, state_d;
  logic [M-2:0]               i_q, i_d;
  logic [DW-1:0]              drain_q, drain_d;
  logic [SW-1:0]              stage_q, stage_d;
  logic [M-1:0]               load_cnt_q, load_cnt_d;
  logic                       done_q, done_d;
  logic [BFLY_LAT-1:0]        dl_vld_q;
  logic [BFLY_LAT-1:0][M-1:0] dl_a_q, dl_b_q;

  logic [M-1:0] gen_a, gen_b;
  logic [M-2:0] gen_tw;
  logic         active, frozen, issuing, src_bank;

  fft_addr_gen #(.M(M), .SW(SW)) u_addr_gen (
    .stage_i   (stage_q),
    .idx_i     (i_q),
    .adr_a_o   (gen_a),
    .adr_b_o   (gen_b),
    .twiddle_o (gen_tw)
  );

  assign active = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
`ifdef FFT_SEQ_STALL_EN
  assign frozen = active & stall;
`else
  assign frozen = 1'b0;
`endif
  assign issuing  = (state_q == ST_ISSUE) && !frozen;
  assign src_bank = stage_q[0];

  // Next-state logic for the FSM and its counters.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    drain_d    = drain_q;
    stage_d    = stage_q;
    load_cnt_d = load_cnt_q;
    done_d     = done_q;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) load_cnt_d = load_cnt_q + 1'b1;
        if (start) begin
          state_d    = ST_ISSUE;
          done_d     = 1'b0;
          load_cnt_d = '0;
          stage_d    = '0;
          i_d        = '0;
          drain_d    = '0;
        end
      end
      ST_ISSUE: begin
        if (!frozen) begin
          if (i_q == I_LAST) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!frozen) begin
          if (drain_q == D_LAST) begin
            drain_d = '0;
            if (stage_q == S_LAST) begin
              state_d = ST_FIN;
            end else begin
              state_d = ST_ISSUE;
              stage_d = stage_q + 1'b1;
              i_d     = '0;
            end
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers; reset aborts any computation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      i_q        <= '0;
      drain_q    <= '0;
      stage_q    <= '0;
      load_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      drain_q    <= drain_d;
      stage_q    <= stage_d;
      load_cnt_q <= load_cnt_d;
      done_q     <= done_d;
    end
  end

  // Write-address delay line matching the butterfly pipeline latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dl_vld_q <= '0;
      dl_a_q   <= '0;
      dl_b_q   <= '0;
    end else if (!frozen) begin
      dl_vld_q[0] <= issuing;
      dl_a_q[0]   <= gen_a;
      dl_b_q[0]   <= gen_b;
      for (int k = 1; k < BFLY_LAT; k++) begin
        dl_vld_q[k] <= dl_vld_q[k-1];
        dl_a_q[k]   <= dl_a_q[k-1];
        dl_b_q[k]   <= dl_b_q[k-1];
      end
    end
  end

  // RAM port steering: load or readout in IDLE, reads on the source bank
  // and delayed write-back on the destination bank while computing.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    done        = done_q;
    stage       = stage_q;
    bfly_en     = 1'b0;
    rd_sel      = 1'b0;
    we0         = 1'b0;
    we1         = 1'b0;
    adr0_a      = '0;
    adr0_b      = '0;
    adr1_a      = '0;
    adr1_b      = '0;
    load_sel    = 1'b0;
    twiddle_adr = '0;
    case (state_q)
      ST_IDLE: begin
        rd_sel = done_q ? RES_BANK : 1'b0;
        if (load_valid) begin
          load_sel = 1'b1;
          we0      = 1'b1;
          adr0_a   = M'(bitrev(32'(load_cnt_q), M));
        end else if (done_q) begin
          if (RES_BANK) adr1_a = rd_adr;
          else          adr0_a = rd_adr;
        end
      end
      ST_ISSUE, ST_DRAIN: begin
        bfly_en = !frozen;
        rd_sel  = src_bank;
        if (state_q == ST_ISSUE) begin
          twiddle_adr = gen_tw;
          if (src_bank) begin
            adr1_a = gen_a;
            adr1_b = gen_b;
          end else begin
            adr0_a = gen_a;
            adr0_b = gen_b;
          end
        end
        if (src_bank) begin
          adr0_a = dl_a_q[BFLY_LAT-1];
          adr0_b = dl_b_q[BFLY_LAT-1];
          we0    = dl_vld_q[BFLY_LAT-1] & !frozen;
        end else begin
          adr1_a = dl_a_q[BFLY_LAT-1];
          adr1_b = dl_b_q[BFLY_LAT-1];
          we1    = dl_vld_q[BFLY_LAT-1] & !frozen;
        end
      end
      ST_FIN: rd_sel = src_bank;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_sequencer.sv
// Self-checking bench for fft_sequencer (N=512, BFLY_LAT=2). A cycle-count
// reference model derives every expected port value from stage/butterfly
// arithmetic; stimulus (loads, rd_adr, junk starts, stalls) is randomized.
// Exercises the FFT_SEQ_STALL_EN stall input when that macro is defined.
module tb_fft_sequencer;

  localparam int N     = 512;
  localparam int M     = 9;
  localparam int L     = 2;
  localparam int SW    = 4;
  localparam int PW    = 2 + 4 * M;
  localparam int CW    = 5 + SW;
  localparam int PER   = N / 2 + L;
  localparam int TOTAL = M * PER;
  localparam bit RES   = (M % 2) == 1;
`ifdef FFT_SEQ_STALL_EN
  localparam bit StallBuilt = 1'b1;
`else
  localparam bit StallBuilt = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, load_valid, stall;
  logic [M-1:0]  rd_adr;
  logic          busy, done, bfly_en, rd_sel, we0, we1, load_sel;
  logic [M-1:0]  adr0_a, adr0_b, adr1_a, adr1_b;
  logic [M-2:0]  twiddle_adr;
  logic [SW-1:0] stage;

  int passCnt   = 0;
  int checkCnt  = 0;
  int loadCnt   = 0;
  bit doneModel = 1'b0;
  int idleStage = 0;

  wire [PW-1:0] portsObs = {we0, we1, adr0_a, adr0_b, adr1_a, adr1_b};
  wire [CW-1:0] ctrlObs  = {busy, done, bfly_en, rd_sel, load_sel, stage};

  always #5 clk = ~clk;

  fft_sequencer #(.N(N), .BFLY_LAT(L)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .load_valid  (load_valid),
`ifdef FFT_SEQ_STALL_EN
    .stall       (stall),
`endif
    .rd_adr      (rd_adr),
    .busy        (busy),
    .done        (done),
    .bfly_en     (bfly_en),
    .rd_sel      (rd_sel),
    .we0         (we0),
    .we1         (we1),
    .adr0_a      (adr0_a),
    .adr0_b      (adr0_b),
    .adr1_a      (adr1_a),
    .adr1_b      (adr1_b),
    .load_sel    (load_sel),
    .twiddle_adr (twiddle_adr),
    .stage       (stage)
  );

  // Reference: bit reversal built MSB-first from the LSBs of x.
  function automatic int mBitrev(input int x);
    int r = 0;
    for (int b = 0; b < M; b++) r = r * 2 + ((x >> b) & 1);
    return r;
  endfunction

  // Reference: M-bit left rotation as modular shift plus wrapped-out bits.
  function automatic int mRotl(input int x, input int s);
    return ((x << s) % N) + (x >> (M - s));
  endfunction

  // Reference: butterfly index with its low (M-1-s) bits dropped.
  function automatic int mTwiddle(input int i, input int s);
    int k = M - 1 - s;
    return (i >> k) << k;
  endfunction

  function automatic logic [PW-1:0] mkPorts(input int w0, input int w1, input int a0a,
                                            input int a0b, input int a1a, input int a1b);
    return {1'(w0), 1'(w1), M'(a0a), M'(a0b), M'(a1a), M'(a1b)};
  endfunction

  // Expected RAM ports in IDLE: sample write, result readout, or nothing.
  function automatic logic [PW-1:0] idleExpPorts(input bit lv);
    if (lv)        return mkPorts(1, 0, mBitrev(loadCnt), 0, 0, 0);
    if (!doneModel) return '0;
    if (RES)       return mkPorts(0, 0, 0, 0, int'(rd_adr), 0);
    return mkPorts(0, 0, int'(rd_adr), 0, 0, 0);
  endfunction

  function automatic logic [CW-1:0] idleExpCtrl(input bit lv);
    return {1'b0, doneModel, 1'b0, doneModel & RES, lv, SW'(idleStage)};
  endfunction

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start  = k[0];
      rd_adr = M'($urandom);
      #1;
      checkCnt++;
      if ({ctrlObs, portsObs, twiddle_adr} !== '0) begin
        $display("[TB] FAIL reset_outputs obs=%h required=0", {ctrlObs, portsObs, twiddle_adr});
      end else passCnt++;
    end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    rd_adr = M'($urandom);
    #1;
    checkCnt++;
    if ({ctrlObs, portsObs, twiddle_adr} !== '0) begin
      $display("[TB] FAIL post_reset_idle obs=%h required=0", {ctrlObs, portsObs, twiddle_adr});
    end else passCnt++;
  endtask

  task automatic test_load(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      start      = 1'b0;
      load_valid = ($urandom_range(0, 9) < 7);
      rd_adr     = M'($urandom);
      #1;
      checkCnt++;
      if (ctrlObs !== idleExpCtrl(load_valid)) begin
        $display("[TB] FAIL load_ctrl cyc=%0d obs=%h required=%h", k, ctrlObs, idleExpCtrl(load_valid));
      end else passCnt++;
      checkCnt++;
      if (portsObs !== idleExpPorts(load_valid)) begin
        $display("[TB] FAIL load_ports cyc=%0d cnt=%0d obs=%h required=%h", k, loadCnt,
                 portsObs, idleExpPorts(load_valid));
      end else passCnt++;
      if (load_valid) loadCnt = (loadCnt + 1) % N;
    end
  endtask

  // Drives start in IDLE (optionally with a sample) and checks that cycle.
  task automatic do_start(input bit withLoad);
    @(negedge clk);
    start      = 1'b1;
    load_valid = withLoad;
    stall      = 1'b0;
    rd_adr     = M'($urandom);
    #1;
    checkCnt++;
    if (ctrlObs !== idleExpCtrl(withLoad)) begin
      $display("[TB] FAIL start_ctrl obs=%h required=%h", ctrlObs, idleExpCtrl(withLoad));
    end else passCnt++;
    checkCnt++;
    if (portsObs !== idleExpPorts(withLoad)) begin
      $display("[TB] FAIL start_ports obs=%h required=%h", portsObs, idleExpPorts(withLoad));
    end else passCnt++;
  endtask

  // Follows one computation cycle by cycle after the accepting edge.
  // stallMode: 0 none, 1 random stalls, 2 seven stalls inside stage 3.
  // abortAt >= 0 asserts reset on that cycle and returns.
  task automatic run_compute(input int stallMode, input int abortAt);
    int step = 0;
    int stalls = 0;
    int edges = 0;
    bit finished = 1'b0;
    bit stalledNow;
    logic [PW-1:0] expP, maskP;
    logic [CW-1:0] expC;
    while (!finished && edges < TOTAL + 1000) begin
      @(negedge clk);
      edges++;
      rd_adr = M'($urandom);
      if (abortAt >= 0 && edges == abortAt) begin
        reset      = 1'b0;
        start      = 1'b0;
        load_valid = 1'b0;
        stall      = 1'b0;
        #1;
        checkCnt++;
        if ({ctrlObs, portsObs, twiddle_adr} !== '0) begin
          $display("[TB] FAIL abort_outputs obs=%h required=0", {ctrlObs, portsObs, twiddle_adr});
        end else passCnt++;
        loadCnt   = 0;
        doneModel = 1'b0;
        idleStage = 0;
        finished  = 1'b1;
      end else if (step <= TOTAL) begin
        start      = ($urandom_range(0, 7) == 0) || (step == 100);
        load_valid = $urandom_range(0, 1) == 1;
        stall      = StallBuilt && (step < TOTAL) &&
                     ((stallMode == 1 && $urandom_range(0, 9) == 0) ||
                      (stallMode == 2 && step == 3 * PER + 5 && stalls < 7));
        stalledNow = stall;
        #1;
        if (step < TOTAL) begin
          int s = step / PER;
          int t = step % PER;
          int ra = 0, rb = 0, tw = 0, wa = 0, wb = 0, wen = 0;
          int dm;
          bit dstCare = (t >= L);
          if (t < N / 2) begin
            ra = mRotl(2 * t, s);
            rb = mRotl(2 * t + 1, s);
            tw = mTwiddle(t, s);
          end
          if (dstCare) begin
            wa  = mRotl(2 * (t - L), s);
            wb  = mRotl(2 * (t - L) + 1, s);
            wen = stalledNow ? 0 : 1;
          end
          dm = dstCare ? N - 1 : 0;
          if (s % 2 == 0) begin
            expP  = mkPorts(0, wen, ra, rb, wa, wb);
            maskP = mkPorts(1, 1, N - 1, N - 1, dm, dm);
          end else begin
            expP  = mkPorts(wen, 0, wa, wb, ra, rb);
            maskP = mkPorts(1, 1, dm, dm, N - 1, N - 1);
          end
          expC = {1'b1, 1'b0, !stalledNow, 1'(s % 2), 1'b0, SW'(s)};
          checkCnt++;
          if (ctrlObs !== expC) begin
            $display("[TB] FAIL compute_ctrl step=%0d stall=%0d obs=%h required=%h",
                     step, stalledNow, ctrlObs, expC);
          end else passCnt++;
          checkCnt++;
          if ((portsObs & maskP) !== (expP & maskP)) begin
            $display("[TB] FAIL compute_ports step=%0d stall=%0d obs=%h required=%h mask=%h",
                     step, stalledNow, portsObs, expP, maskP);
          end else passCnt++;
          checkCnt++;
          if (twiddle_adr !== (M-1)'(tw)) begin
            $display("[TB] FAIL twiddle step=%0d obs=%0d required=%0d", step, twiddle_adr, tw);
          end else passCnt++;
          if (stalledNow) stalls++;
          else step++;
        end else begin
          expC = {1'b1, 1'b0, 1'b0, 1'((M - 1) % 2), 1'b0, SW'(M - 1)};
          checkCnt++;
          if ({ctrlObs, portsObs, twiddle_adr} !== {expC, {PW{1'b0}}, {(M-1){1'b0}}}) begin
            $display("[TB] FAIL fin_cycle obs=%h required=%h", {ctrlObs, portsObs, twiddle_adr},
                     {expC, {PW{1'b0}}, {(M-1){1'b0}}});
          end else passCnt++;
          step++;
        end
      end else begin
        start      = 1'b0;
        load_valid = 1'b0;
        stall      = 1'b0;
        rd_adr     = M'(37);
        #1;
        doneModel = 1'b1;
        idleStage = M - 1;
        loadCnt   = 0;
        checkCnt++;
        if (ctrlObs !== idleExpCtrl(1'b0)) begin
          $display("[TB] FAIL done_edge edges_after_start=%0d stalls=%0d obs=%h required=%h",
                   edges - 1, stalls, ctrlObs, idleExpCtrl(1'b0));
        end else passCnt++;
        checkCnt++;
        if ({portsObs, twiddle_adr} !== {mkPorts(0, 0, 0, 0, 37, 0), {(M-1){1'b0}}}) begin
          $display("[TB] FAIL readout_37 obs=%h required=%h", {portsObs, twiddle_adr},
                   {mkPorts(0, 0, 0, 0, 37, 0), {(M-1){1'b0}}});
        end else passCnt++;
        $display("[TB] done observed %0d edges after start (%0d stalled)", edges - 1, stalls);
        finished = 1'b1;
      end
    end
    if (!finished) begin
      checkCnt++;
      $display("[TB] FAIL compute_timeout edges=%0d required_done_by=%0d", edges, TOTAL + 1 + stalls);
    end
    start      = 1'b0;
    load_valid = 1'b0;
    stall      = 1'b0;
  endtask

  task automatic test_start_with_load();
    do_start(1'b1);
    run_compute(0, -1);
  endtask

  task automatic test_back_to_back();
    do_start(1'b0);
    run_compute(1, -1);
  endtask

  task automatic test_abort();
    do_start(1'b0);
    run_compute(0, 500);
    @(negedge clk);
    reset = 1'b1;
    rd_adr = M'($urandom);
    #1;
    checkCnt++;
    if ({ctrlObs, portsObs, twiddle_adr} !== '0) begin
      $display("[TB] FAIL abort_release obs=%h required=0", {ctrlObs, portsObs, twiddle_adr});
    end else passCnt++;
    do_start(1'b0);
    run_compute(0, -1);
  endtask

`ifdef FFT_SEQ_STALL_EN
  task automatic test_stall();
    do_start(1'b0);
    run_compute(2, -1);
  endtask
`endif

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    load_valid = 1'b0;
    stall      = 1'b0;
    rd_adr     = '0;
    test_reset();
    test_load(900);
    test_start_with_load();
    test_load(300);
    test_back_to_back();
    test_abort();
`ifdef FFT_SEQ_STALL_EN
    test_stall();
`endif
    test_load(100);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/fft_sequencer.md
Name: fft_sequencer

Overview:
Control and address-generation block for the radix-2 ping-pong FFT datapath (butterfly unit, twiddle ROM, two dual-port RAMs).
- Writes incoming samples into RAM0 in bit-reversed order.
- Issues N/2 butterflies per stage for M stages, alternating the source and destination RAM.
- Drains the butterfly pipeline between stages.
- Hands the result RAM to the readout port.

Parameters:
N, 512, FFT length, power of two, >= 4
M, log2(N), address width and stage count
BFLY_LAT, 2, butterfly pipeline latency in cycles, >= 1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
start  in  1  start request; accepted only in IDLE
load_valid  in  1  one input sample present this cycle
rd_adr  in  M  readout address for the result bank
busy  out  1  high from start acceptance until done
done  out  1  level; high when result valid, cleared by next accepted start
bfly_en  out  1  butterfly pipeline advance enable
rd_sel  out  1  0: source/result is RAM0; 1: RAM1
we0, we1  out  1 each  RAM0/RAM1 write enables (both ports)
adr0_a, adr0_b, adr1_a, adr1_b  out  M each  RAM port addresses
load_sel  out  1  1: RAM write data taken from sample bus
twiddle_adr  out  M-1  twiddle ROM address
stage  out  log2(M)+1  current stage index

Behaviour:
- Reset (async, reset=0): state IDLE; all counters 0; every output 0.
- States:
  - IDLE: accepts start or load_valid.
  - ISSUE: one butterfly per cycle.
  - DRAIN: BFLY_LAT cycles, no reads.
  - FIN: one cycle; sets done, returns to IDLE.
- IDLE load:
  - Each load_valid → load_sel=1, we0=1, adr0_a=bitrev(load_cnt); load_cnt++.
  - load_cnt wraps N-1→0.
  - load_valid is ignored when busy.
- Start handling:
  - start and load_valid in the same IDLE cycle: the sample is written and start is accepted.
  - Accepted start: busy=1, done=0, load_cnt=0, stage=0, i=0 → ISSUE.
  - start while busy is ignored.
- ISSUE, stage s, butterfly i (0..N/2-1):
  - Read addresses: adrA=rotl_M(2i, s), adrB=rotl_M(2i+1, s).
  - Addresses go on source bank ports a/b; source bank = s[0].
  - twiddle_adr = i with low (M-1-s) bits cleared.
- Write-back: read addresses are delayed BFLY_LAT cycles through an internal delay line, then appear on destination bank (= !s[0]) ports with that bank's we=1. Read and write addresses therefore coexist on opposite banks.
- Stage transitions:
  - i=N/2-1 issued → DRAIN.
  - After BFLY_LAT cycles: if s=M-1 → FIN, else s++, i=0 → ISSUE.
  - No read of stage s+1 occurs before the last write of stage s.
- Latency: done rises M*(N/2+BFLY_LAT)+1 edges after the accepting edge (N=512, BFLY_LAT=2: 2323). busy falls on the same edge.
- rd_sel:
  - During compute: equals source bank.
  - In IDLE after done: result bank = M[0] (N=512 → RAM1).
- IDLE readout, no load_valid: result bank port a = rd_adr, we=0.
- bfly_en=1 throughout ISSUE/DRAIN, else 0.
- Reset mid-compute: immediate abort to IDLE, done=0, RAM contents undefined.

Optional Feature:
FFT_SEQ_STALL_EN: adds input `stall`.
- Defined: while stall=1 in ISSUE/DRAIN, i, drain counter and delay line freeze; bfly_en=0; we0=we1=0; addresses hold.
- Latency grows by exactly the number of stalled cycles.
- Undefined: port absent; behaviour as above.

Decomposition:
- Package fft_pkg: N, M, BFLY_LAT defaults; state enum; functions log2, bitrev, rotl.
- Sub-module fft_addr_gen: combinational (s, i) → adrA, adrB, twiddle_adr.
- The sequencer holds the FSM, counters and the write-address delay line.

Test Plan:
- Load 8 samples (N=8, M=3) → adr0_a sequence 0,4,2,6,1,5,3,7; we0=1 each cycle; load_cnt wraps to 0.
- Start after load, N=8 → stage0 i=1: adr0_a=2, adr0_b=3; stage1 i=1: adr1_a=4, adr1_b=6; stage2 twiddle_adr = i; writes to the opposite bank lag by BFLY_LAT.
- N=512, BFLY_LAT=2: check done rises exactly 2323 edges after start; rd_sel=1; rd_adr=37 → adr1_a=37, we1=0.
- Pulse start at issue cycle 100 → no effect. Assert reset at cycle 500 → all outputs 0 within the same cycle; a later start completes normally.
- start and load_valid in the same IDLE cycle → sample written at bitrev(load_cnt); compute begins next cycle.
- FFT_SEQ_STALL_EN: 7 stall cycles during stage 3 → done delayed by exactly 7; no writes while stalled; address sequence unchanged.
